// File: rtl/ctrl_pkt_gen.sv
// Control-path packet generator: turns a table-write request plus payload beats
// into a 256-bit AXI-Stream control packet (header beat followed by nbeats payload beats).
module ctrl_pkt_gen #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 256,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CTRL_PORT            = 16'hf1f2
) (
  input  logic                              clk,
  input  logic                              rst_n,

  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [7:0]                        req_module_id,
  input  logic [3:0]                        req_ctrl_flag,
  input  logic [3:0]                        req_tbl_type,
  input  logic [7:0]                        req_index,
  input  logic [2:0]                        req_nbeats,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    pld_tdata,
  input  logic                              pld_valid,
  output logic                              pld_ready,

  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast,
  input  logic                              c_m_axis_tready,

  output logic [31:0]                       pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PLD
  } state_t;

  state_t                           state;
  logic [2:0]                       nbeats_q;
  logic [2:0]                       beat_cnt;
  logic [C_S_AXIS_DATA_WIDTH-1:0]   hdr_beat;
  logic [15:0]                      req_len;
  logic                             req_fire;
  logic                             pld_fire;
  logic                             out_fire;

  // Payload is only pulled while beats remain, so nothing beyond the packet is consumed.
  assign req_ready = (state == IDLE);
  assign pld_ready = (state == PLD) && (beat_cnt != 3'd0) &&
                     (!c_m_axis_tvalid || c_m_axis_tready);

  assign req_fire = req_valid && req_ready;
  assign pld_fire = pld_valid && pld_ready;
  assign out_fire = c_m_axis_tvalid && c_m_axis_tready;

  // Packet byte length: 32 bytes per beat, header included.
  assign req_len = {8'd0, req_nbeats, 5'd0} + 16'd32;

  always_comb begin
    hdr_beat            = '0;
    hdr_beat[79:64]     = CTRL_PORT;
    hdr_beat[119:112]   = req_module_id;
    hdr_beat[123:120]   = req_ctrl_flag;
    hdr_beat[127:124]   = req_tbl_type;
    hdr_beat[135:128]   = req_index;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      nbeats_q        <= '0;
      beat_cnt        <= '0;
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast  <= 1'b0;
      pkt_cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            nbeats_q        <= req_nbeats;
            c_m_axis_tdata  <= hdr_beat;
            c_m_axis_tuser  <= {{(C_S_AXIS_TUSER_WIDTH-16){1'b0}}, req_len};
            c_m_axis_tkeep  <= '1;
            c_m_axis_tvalid <= 1'b1;
            c_m_axis_tlast  <= (req_nbeats == 3'd0);
            state           <= HDR;
          end
        end

        HDR: begin
          if (out_fire) begin
            c_m_axis_tvalid <= 1'b0;
            if (nbeats_q == 3'd0) begin
              pkt_cnt <= pkt_cnt + 32'd1;
              state   <= IDLE;
            end else begin
              beat_cnt <= nbeats_q;
              state    <= PLD;
            end
          end
        end

        PLD: begin
          // A new beat may replace one being handshaken in the same cycle.
          if (pld_fire) begin
            c_m_axis_tdata  <= pld_tdata;
            c_m_axis_tvalid <= 1'b1;
            c_m_axis_tlast  <= (beat_cnt == 3'd1);
            beat_cnt        <= beat_cnt - 3'd1;
          end else if (out_fire) begin
            c_m_axis_tvalid <= 1'b0;
            if (c_m_axis_tlast) begin
              pkt_cnt <= pkt_cnt + 32'd1;
              state   <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
